// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add
// multiply and restoring unsigned divide, sequenced by an IDLE/BUSY/DONE FSM.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_LUI  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic [CW-1:0]    cnt;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fast_res, acc_n, a_n, b_n, fin_res;
  logic [WIDTH:0]   shifted, diff;
  logic             long_op;

  // Single-cycle datapath; DIVU/REMU only land here when the divisor is zero.
  always_comb begin
    shamt    = B_i[SHW-1:0];
    fast_res = '0;
    case (ALU_Operation_i)
      OP_ADD:  fast_res = A_i + B_i;
      OP_SUB:  fast_res = A_i - B_i;
      OP_AND:  fast_res = A_i & B_i;
      OP_OR:   fast_res = A_i | B_i;
      OP_XOR:  fast_res = A_i ^ B_i;
      OP_LUI:  fast_res = {B_i[WIDTH-1:12], 12'b0};
      OP_SLL:  fast_res = A_i << shamt;
      OP_SRL:  fast_res = A_i >> shamt;
      OP_SRA:  fast_res = $signed(A_i) >>> shamt;
      OP_DIVU: fast_res = '1;
      OP_REMU: fast_res = A_i;
      default: fast_res = '0;
    endcase
    long_op = (ALU_Operation_i == OP_MUL) ||
              (((ALU_Operation_i == OP_DIVU) || (ALU_Operation_i == OP_REMU)) && (B_i != '0));
  end

  // One iteration: MUL adds the shifted multiplicand per multiplier bit;
  // divide shifts the dividend MSB into the partial remainder and restores on borrow.
  always_comb begin
    shifted = {acc, a_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    acc_n   = acc;
    a_n     = a_q;
    b_n     = b_q;
    if (op_q == OP_MUL) begin
      acc_n = acc + (b_q[0] ? a_q : '0);
      a_n   = a_q << 1;
      b_n   = b_q >> 1;
    end else if (!diff[WIDTH]) begin
      acc_n = diff[WIDTH-1:0];
      a_n   = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = shifted[WIDTH-1:0];
      a_n   = {a_q[WIDTH-2:0], 1'b0};
    end
    fin_res = (op_q == OP_DIVU) ? a_n : acc_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc          <= '0;
      cnt          <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      ALU_Result_o <= '0;
      Zero_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          op_q   <= ALU_Operation_i;
          a_q    <= A_i;
          b_q    <= B_i;
          acc    <= '0;
          cnt    <= '0;
          busy_o <= 1'b1;
          if (long_op) begin
            state <= BUSY;
          end else begin
            state        <= DONE;
            done_o       <= 1'b1;
            ALU_Result_o <= fast_res;
            Zero_o       <= (fast_res == '0);
          end
        end
        BUSY: begin
          acc <= acc_n;
          a_q <= a_n;
          b_q <= b_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state        <= DONE;
            done_o       <= 1'b1;
            ALU_Result_o <= fin_res;
            Zero_o       <= (fin_res == '0);
          end
        end
        default: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: 32-bit and 16-bit instances, directed vectors.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st32 = 0, bsy32, dn32, z32;
  logic [3:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, r32;
  logic        st16 = 0, bsy16, dn16, z16;
  logic [3:0]  op16 = 0;
  logic [15:0] a16 = 0, b16 = 0, r16;

  alu_multicycle #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst), .start_i(st32), .ALU_Operation_i(op32), .A_i(a32), .B_i(b32),
    .busy_o(bsy32), .done_o(dn32), .ALU_Result_o(r32), .Zero_o(z32));
  alu_multicycle #(.WIDTH(16)) u16 (
    .clk(clk), .reset(rst), .start_i(st16), .ALU_Operation_i(op16), .A_i(a16), .B_i(b16),
    .busy_o(bsy16), .done_o(dn16), .ALU_Result_o(r16), .Zero_o(z16));

  typedef struct {
    logic [63:0] res;
    logic        z;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q32[$], q16[$];
  int   cyc = 0;
  int   n_vec = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && dn32) begin
      if (q32.size() == 0) chk("unexpected_done32", 1, 0);
      else begin
        e = q32.pop_front();
        chk("res32", {32'b0, r32}, e.res);
        chk("zero32", z32, e.z);
        chk("lat32", cyc - e.issue, e.lat);
      end
    end
    if (!rst && dn16) begin
      if (q16.size() == 0) chk("unexpected_done16", 1, 0);
      else begin
        e = q16.pop_front();
        chk("res16", {48'b0, r16}, e.res);
        chk("zero16", z16, e.z);
        chk("lat16", cyc - e.issue, e.lat);
      end
    end
  end

  // Issue one op, scramble inputs after acceptance, optionally pulse start mid-BUSY,
  // and wait for return to IDLE counting busy-but-not-done cycles.
  task automatic issue(input bit w16, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] want, input int lat, input bit pulse);
    exp_t e;
    int   bcnt = 0;
    bit   idle = 0;
    @(negedge clk);
    e.res = want; e.lat = lat; e.issue = cyc;
    if (w16) begin
      st16 = 1; op16 = op; a16 = a[15:0]; b16 = b[15:0];
      e.z = (want[15:0] == 16'h0); q16.push_back(e);
    end else begin
      st32 = 1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
      e.z = (want[31:0] == 32'h0); q32.push_back(e);
    end
    for (int k = 0; k < 200 && !idle; k++) begin
      @(negedge clk);
      if (k == 0) begin
        st16 = 0; st32 = 0;
        a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); op16 = 4'($urandom);
      end
      if (pulse && k == 5) begin st32 = 1; op32 = 4'b0000; end
      if (pulse && k == 6) st32 = 0;
      if (w16 ? (bsy16 && !dn16) : (bsy32 && !dn32)) bcnt++;
      if (!(w16 ? bsy16 : bsy32)) idle = 1;
    end
    if (!idle) chk("timeout_idle", 0, 1);
    chk("busy_cycles", bcnt, lat - 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_res32", r32, 0);
    chk("rst_zero32", z32, 0);
    chk("rst_busy32", bsy32, 0);
    chk("rst_done32", dn32, 0);
    rst = 0;

    issue(0, 4'b0000, 64'hFFFFFFFF, 64'h1, 64'h0, 1, 0);
    issue(0, 4'b0001, 64'h5, 64'h7, 64'hFFFFFFFE, 1, 0);
    issue(0, 4'b0100, 64'hF0F0F0F0, 64'h0FF00FF0, 64'h00F000F0, 1, 0);
    issue(0, 4'b0101, 64'hF0000000, 64'h0000000F, 64'hF000000F, 1, 0);
    issue(0, 4'b0110, 64'hAAAAAAAA, 64'hFFFFFFFF, 64'h55555555, 1, 0);
    issue(0, 4'b0111, 64'hDEAD, 64'h12345ABC, 64'h12345000, 1, 0);
    issue(0, 4'b1000, 64'h1, 64'h21, 64'h2, 1, 0);
    issue(0, 4'b1010, 64'h80000000, 64'h4, 64'h08000000, 1, 0);
    issue(0, 4'b1011, 64'h80000000, 64'h24, 64'hF8000000, 1, 0);
    issue(0, 4'b1100, 64'hFFFFFFFF, 64'h3, 64'hFFFFFFFD, 33, 1);
    issue(0, 4'b1100, 64'h7, 64'h6, 64'h2A, 33, 0);
    issue(0, 4'b1100, 64'h10000, 64'h10000, 64'h0, 33, 0);
    issue(0, 4'b1101, 64'd100, 64'd7, 64'd14, 33, 0);
    issue(0, 4'b1110, 64'd100, 64'd7, 64'd2, 33, 0);
    issue(0, 4'b1101, 64'd100, 64'd0, 64'hFFFFFFFF, 1, 0);
    issue(0, 4'b1110, 64'd100, 64'd0, 64'd100, 1, 0);
    issue(0, 4'b0010, 64'h1234, 64'h5678, 64'h0, 1, 0);
    issue(0, 4'b1101, 64'hFFFFFFFF, 64'h10, 64'h0FFFFFFF, 33, 0);
    issue(0, 4'b1110, 64'hFFFFFFFF, 64'h10, 64'hF, 33, 0);

    issue(1, 4'b1100, 64'h0100, 64'h0100, 64'h0, 17, 0);
    issue(1, 4'b1111, 64'h1234, 64'h5678, 64'h0, 1, 0);
    issue(1, 4'b0000, 64'hFFFF, 64'h2, 64'h1, 1, 0);

    // Abort a MUL partway through; previous result (0xF) is nonzero so the clear is visible.
    @(negedge clk);
    st32 = 1; op32 = 4'b1100; a32 = 32'd5; b32 = 32'd5;
    @(negedge clk);
    st32 = 0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", bsy32, 1);
    rst = 1;
    #1;
    chk("abort_busy", bsy32, 0);
    chk("abort_done", dn32, 0);
    chk("abort_res", r32, 0);
    chk("abort_zero", z32, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    issue(0, 4'b0000, 64'd2, 64'd3, 64'd5, 1, 0);

    repeat (5) @(negedge clk);
    chk("q32_empty", q32.size(), 0);
    chk("q16_empty", q16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
